// File: rtl/spi_burst_ram.sv
// -----------------------------------------------------------------------------
// spi_burst_ram
//
// SPI slave with an integrated single-port RAM. The SPI pins are sampled
// on every rising edge of the system clock (one bit per clk cycle).
// A transaction starts with a 2-bit opcode:
//   00 : load the write pointer (ADDR_SIZE bits)
//   01 : burst write, one memory word per DATA_WIDTH bits, write pointer
//        auto-increments
//   10 : load the read pointer (ADDR_SIZE bits)
//   11 : burst read, gapless MSB-first stream on MISO, read pointer
//        auto-increments
// Pointers wrap to 0 when they reach MEM_DEPTH. An access through a
// pointer >= MEM_DEPTH is dropped (write) or returns zeros (read) and sets
// the sticky err flag.
//
// Ports
//   clk    : system clock, all sampling on the rising edge
//   rst_n  : asynchronous active-low reset (RAM contents are kept)
//   SS_n   : slave select, active low, frames a transaction
//   MOSI   : serial data in, MSB first
//   MISO   : serial data out, MSB first, registered
//   busy   : high while a transaction is in progress
//   err    : sticky out-of-range flag, cleared only by reset
// -----------------------------------------------------------------------------
module spi_burst_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic err
);

  localparam int CNT_MAX = (DATA_WIDTH > ADDR_SIZE) ? DATA_WIDTH : ADDR_SIZE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]   ADDR_LAST = CNT_W'(ADDR_SIZE - 1);
  localparam logic [ADDR_SIZE:0] DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  state_e                  state_q,   state_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    op_q,      op_d;
  logic [ADDR_SIZE-1:0]    addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0]   data_sh_q, data_sh_d;
  logic [ADDR_SIZE-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [ADDR_SIZE-1:0]    rd_ptr_q,  rd_ptr_d;
  logic                    err_q,     err_d;
  logic                    miso_q,    miso_d;
  logic                    busy_q,    busy_d;

  logic                    mem_we_s;
  logic [DATA_WIDTH-1:0]   mem_wd_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  // True when the pointer addresses a physically present word.
  function automatic logic ptr_in_range(input logic [ADDR_SIZE-1:0] ptr);
    ptr_in_range = ({1'b0, ptr} < DEPTH_EXT);
  endfunction

  // Pointer advance with wrap to zero at MEM_DEPTH.
  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] ptr);
    logic [ADDR_SIZE:0] sum;
    sum = {1'b0, ptr} + {{ADDR_SIZE{1'b0}}, 1'b1};
    if (sum >= DEPTH_EXT) begin
      ptr_inc = {ADDR_SIZE{1'b0}};
    end else begin
      ptr_inc = sum[ADDR_SIZE-1:0];
    end
  endfunction

  // MSB-first shift of one serial bit into an address-sized register.
  function automatic logic [ADDR_SIZE-1:0] shift_addr(input logic [ADDR_SIZE-1:0] v,
                                                      input logic b);
    shift_addr = (v << 1'b1) | ADDR_SIZE'(b);
  endfunction

  // MSB-first shift of one serial bit into a word-sized register.
  function automatic logic [DATA_WIDTH-1:0] shift_data(input logic [DATA_WIDTH-1:0] v,
                                                      input logic b);
    shift_data = (v << 1'b1) | DATA_WIDTH'(b);
  endfunction

  // Word presented to the read path; out-of-range pointers read as zero.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    if (ptr_in_range(rd_ptr_q)) begin
      rd_word_s = mem[rd_ptr_q[MEM_AW-1:0]];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Next-state, datapath and output computation for the serial engine.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = err_q;
    mem_we_s  = 1'b0;
    mem_wd_s  = shift_data(data_sh_q, MOSI);

    if ((state_q != ST_IDLE) && SS_n) begin
      // Deselect abandons any partial word/address; earlier increments stay.
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // MOSI is not sampled on the selecting edge.
          if (!SS_n) begin
            state_d = ST_CMD;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_CMD: begin
          if (cnt_q == CNT_ZERO) begin
            op_d  = MOSI;
            cnt_d = CNT_ONE;
          end else begin
            cnt_d     = CNT_ZERO;
            addr_sh_d = {ADDR_SIZE{1'b0}};
            // Cleared so MISO stays low until the first word is loaded.
            data_sh_d = {DATA_WIDTH{1'b0}};
            case ({op_q, MOSI})
              2'b00:   state_d = ST_WR_ADDR;
              2'b01:   state_d = ST_WR_DATA;
              2'b10:   state_d = ST_RD_ADDR;
              2'b11:   state_d = ST_RD_DATA;
              default: state_d = ST_IDLE;
            endcase
          end
        end

        ST_WR_ADDR, ST_RD_ADDR: begin
          addr_sh_d = shift_addr(addr_sh_q, MOSI);
          if (cnt_q == ADDR_LAST) begin
            if (state_q == ST_WR_ADDR) begin
              wr_ptr_d = addr_sh_d;
            end else begin
              rd_ptr_d = addr_sh_d;
            end
            state_d = ST_DONE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_WR_DATA: begin
          data_sh_d = shift_data(data_sh_q, MOSI);
          if (cnt_q == DATA_LAST) begin
            cnt_d    = CNT_ZERO;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            if (ptr_in_range(wr_ptr_q)) begin
              mem_we_s = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_RD_DATA: begin
          // cnt 0 loads a fresh word; the remaining counts shift it out,
          // so consecutive words follow without a gap.
          if (cnt_q == CNT_ZERO) begin
            data_sh_d = rd_word_s;
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            cnt_d     = CNT_ONE;
            if (!ptr_in_range(rd_ptr_q)) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end else begin
            data_sh_d = shift_data(data_sh_q, 1'b0);
            if (cnt_q == DATA_LAST) begin
              cnt_d = CNT_ZERO;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_RD_DATA) begin
      miso_d = data_sh_d[DATA_WIDTH-1];
    end else begin
      miso_d = 1'b0;
    end
  end

  // Engine state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      op_q      <= 1'b0;
      addr_sh_q <= {ADDR_SIZE{1'b0}};
      data_sh_q <= {DATA_WIDTH{1'b0}};
      wr_ptr_q  <= {ADDR_SIZE{1'b0}};
      rd_ptr_q  <= {ADDR_SIZE{1'b0}};
      err_q     <= 1'b0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
    end
  end

  // RAM write port; contents deliberately survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[wr_ptr_q[MEM_AW-1:0]] <= mem_wd_s;
    end
  end

  assign MISO = miso_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Bench for spi_burst_ram: unit 0 uses default sizing, unit 1 has
// MEM_DEPTH = 200 so out-of-range pointers are reachable.
module tb_spi_burst_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ss_n;
  logic [1:0] mosi;
  logic [1:0] miso;
  logic [1:0] busy;
  logic [1:0] err;

  spi_burst_ram dut0 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi[0]),
    .MISO(miso[0]), .busy(busy[0]), .err(err[0])
  );

  spi_burst_ram #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(200)) dut1 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi[1]),
    .MISO(miso[1]), .busy(busy[1]), .err(err[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model (frame-position based) ----------------
  int         depth [2] = '{256, 200};
  int         m_e   [2];          // edges since select, -1 when idle
  logic [1:0] m_op  [2];
  logic [7:0] m_acc [2];
  logic [7:0] m_dacc[2];
  logic [7:0] m_wr  [2];
  logic [7:0] m_rd  [2];
  logic [7:0] m_word[2];
  logic       m_wk  [2];
  logic       m_err [2];
  logic       x_busy[2];
  logic       x_miso[2];
  logic       x_mchk[2];
  logic [7:0] mem_m [2][256];
  bit         known [2][256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] nxt(input int u, input logic [7:0] p);
    int s;
    s = int'(p) + 1;
    return (s >= depth[u]) ? 8'h00 : 8'(s);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_e[u] = -1; m_wr[u] = 8'h00; m_rd[u] = 8'h00; m_err[u] = 1'b0;
      x_busy[u] = 1'b0; x_miso[u] = 1'b0; x_mchk[u] = 1'b1;
    end
  endtask

  task automatic model_step(input int u, input logic ss, input logic mi);
    int p;
    x_mchk[u] = 1'b1;
    x_miso[u] = 1'b0;
    if (ss) begin
      m_e[u] = -1;
      x_busy[u] = 1'b0;
    end else begin
      x_busy[u] = 1'b1;
      if (m_e[u] < 0) begin
        m_e[u] = 0; m_acc[u] = 8'h00; m_dacc[u] = 8'h00; m_op[u] = 2'b00;
      end else begin
        m_e[u]++;
        if (m_e[u] == 1) begin
          m_op[u] = {mi, 1'b0};
        end else if (m_e[u] == 2) begin
          m_op[u][0] = mi;
          if (m_op[u] == 2'd3) x_mchk[u] = 1'b0;
        end else begin
          p = m_e[u] - 3;
          case (m_op[u])
            2'd0, 2'd2: begin
              if (p < 8) begin
                m_acc[u] = {m_acc[u][6:0], mi};
                if (p == 7) begin
                  if (m_op[u] == 2'd0) m_wr[u] = m_acc[u];
                  else                 m_rd[u] = m_acc[u];
                end
              end
            end
            2'd1: begin
              m_dacc[u] = {m_dacc[u][6:0], mi};
              if (p % 8 == 7) begin
                if (int'(m_wr[u]) < depth[u]) begin
                  mem_m[u][m_wr[u]] = m_dacc[u];
                  known[u][m_wr[u]] = 1'b1;
                end else begin
                  m_err[u] = 1'b1;
                end
                m_wr[u] = nxt(u, m_wr[u]);
              end
            end
            default: begin
              if (p % 8 == 0) begin
                if (int'(m_rd[u]) < depth[u]) begin
                  m_word[u] = mem_m[u][m_rd[u]];
                  m_wk[u]   = known[u][m_rd[u]];
                end else begin
                  m_word[u] = 8'h00;
                  m_wk[u]   = 1'b1;
                  m_err[u]  = 1'b1;
                end
                m_rd[u] = nxt(u, m_rd[u]);
              end
              x_miso[u] = m_word[u][7 - (p % 8)];
              x_mchk[u] = m_wk[u];
            end
          endcase
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int u = 0; u < 2; u++) begin
          check($sformatf("busy%0d", u), busy[u], x_busy[u]);
          check($sformatf("err%0d", u), err[u], m_err[u]);
          if (x_mchk[u]) check($sformatf("miso%0d", u), miso[u], x_miso[u]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input int u, input logic ssv, input logic mv);
    for (int v = 0; v < 2; v++) begin
      if (v == u) begin
        ss_n[v] = ssv; mosi[v] = mv;
      end else begin
        ss_n[v] = 1'b1; mosi[v] = 1'($urandom % 2);
      end
    end
    @(posedge clk);
    model_step(0, ss_n[0], mosi[0]);
    model_step(1, ss_n[1], mosi[1]);
    @(negedge clk);
  endtask

  task automatic frame(input int u, input logic [1:0] op, input logic [63:0] pay,
                       input int n, input int rst_at, output logic [63:0] cap);
    logic b;
    cap = 64'h0;
    step(u, 1'b0, 1'($urandom % 2));
    step(u, 1'b0, op[1]);
    step(u, 1'b0, op[0]);
    for (int i = 0; i < n; i++) begin
      if (op == 2'd3) b = 1'($urandom % 2);
      else            b = pay[n-1-i];
      step(u, 1'b0, b);
      cap = {cap[62:0], miso[u]};
      if (i == rst_at) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_miso", miso[u], 1'b0);
        check("rst_mid_busy", busy[u], 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    step(u, 1'b1, 1'($urandom % 2));
  endtask

  logic [63:0] cap;
  int          u_r, n_r;
  logic [1:0]  op_r;

  initial begin
    rst_n = 1'b0; ss_n = 2'b11; mosi = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b1, 1'b0);
    check("reset_miso0", miso[0], 1'b0); check("reset_busy0", busy[0], 1'b0);
    check("reset_err0", err[0], 1'b0);   check("reset_miso1", miso[1], 1'b0);
    check("reset_busy1", busy[1], 1'b0); check("reset_err1", err[1], 1'b0);
    chk_en = 1'b1;

    // Pointers start at zero: write without address, read without address.
    frame(0, 2'b01, 64'h3C, 8, -1, cap);
    frame(0, 2'b11, 64'h0, 8, -1, cap);
    check("ptr_reset_read", cap[7:0], 8'h3C);

    // Single write then read.
    frame(0, 2'b00, 64'h10, 8, -1, cap);
    frame(0, 2'b01, 64'hA5, 8, -1, cap);
    frame(0, 2'b10, 64'h10, 8, -1, cap);
    frame(0, 2'b11, 64'h0, 8, -1, cap);
    check("single_read", cap[7:0], 8'hA5);

    // Burst with wrap.
    frame(0, 2'b00, 64'hFE, 8, -1, cap);
    frame(0, 2'b01, 64'h112233, 24, -1, cap);
    frame(0, 2'b10, 64'hFE, 8, -1, cap);
    frame(0, 2'b11, 64'h0, 24, -1, cap);
    check("wrap_read", cap[23:0], 24'h112233);

    // Abort after 5 data bits: no write, write pointer unchanged.
    frame(0, 2'b00, 64'h40, 8, -1, cap);
    frame(0, 2'b01, 64'h7788, 16, -1, cap);
    frame(0, 2'b01, 64'h1F, 5, -1, cap);
    check("abort_busy", busy[0], 1'b0);
    frame(0, 2'b01, 64'h99, 8, -1, cap);
    frame(0, 2'b10, 64'h40, 8, -1, cap);
    frame(0, 2'b11, 64'h0, 24, -1, cap);
    check("abort_read", cap[23:0], 24'h778899);

    // Out of range on the 200-deep unit.
    frame(1, 2'b00, 64'hC8, 8, -1, cap);
    check("oor_err_before", err[1], 1'b0);
    frame(1, 2'b01, 64'h5A, 8, -1, cap);
    check("oor_err_after", err[1], 1'b1);
    frame(1, 2'b01, 64'h66, 8, -1, cap);
    frame(1, 2'b10, 64'hC8, 8, -1, cap);
    frame(1, 2'b11, 64'h0, 16, -1, cap);
    check("oor_read", cap[15:0], 16'h0066);

    // Reset during bit 3 of word 1 of a burst read.
    frame(0, 2'b10, 64'hFE, 8, -1, cap);
    frame(0, 2'b11, 64'h0, 24, 11, cap);
    check("rst_err1_cleared", err[1], 1'b0);
    frame(0, 2'b10, 64'hFE, 8, -1, cap);
    frame(0, 2'b11, 64'h0, 24, -1, cap);
    check("post_rst_read", cap[23:0], 24'h112233);

    // Randomized frames, including partial and over-long ones.
    for (int t = 0; t < 120; t++) begin
      u_r  = int'($urandom % 2);
      op_r = 2'($urandom % 4);
      if (op_r[0] == 1'b0) n_r = int'($urandom_range(0, 10));
      else                 n_r = int'($urandom_range(0, 26));
      frame(u_r, op_r, {$urandom, $urandom}, n_r, -1, cap);
      if ($urandom % 4 == 0) step(u_r, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_ram.md
# spi_burst_ram

Parametrised SPI slave with an integrated single-port synchronous RAM. It is the next generation of the SPI-plus-RAM slave subsystem. It adds configurable data, address and depth sizing, separate write and read pointers, and burst transfers in which the pointer auto-increments while SS_n stays low. It sits directly on the SPI pins and is clocked by the system clock, sampling one bit per clk cycle.

## Interface
- DATA_WIDTH, 8: bits per memory word and per burst word.
- ADDR_SIZE, 8: width of the address field and of both pointers.
- MEM_DEPTH, 256: number of words. Must be ≤ 2**ADDR_SIZE.

- clk  input  1  system clock; all sampling is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  slave select, active low; frames a transaction.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first, registered.
- busy  output  1  high whenever state ≠ IDLE.
- err  output  1  sticky out-of-range flag; cleared only by reset.

## Operation
- States: IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE.
- IDLE → CMD on the first edge that samples SS_n low. MOSI is not sampled on that edge.
- CMD shifts 2 opcode bits on the next 2 edges, then branches:
  - 00 → WR_ADDR
  - 01 → WR_DATA
  - 10 → RD_ADDR
  - 11 → RD_DATA
- WR_ADDR: shift ADDR_SIZE bits into wr_ptr, then → DONE.
- RD_ADDR: same as WR_ADDR, but the bits go into rd_ptr.
- DONE: ignores MOSI until SS_n goes high.
- WR_DATA (burst):
  - Shift DATA_WIDTH bits per word.
  - On the edge that samples a word's last bit: mem[wr_ptr] ← word, and wr_ptr increments.
  - Repeats for every further full word while SS_n stays low.
- RD_DATA (burst):
  - The edge after the opcode loads the shift register with mem[rd_ptr], and rd_ptr increments.
  - Each of the next DATA_WIDTH−1 edges shifts the register one bit.
  - The edge after the last bit loads the next word. Output is therefore a gapless stream, and MOSI is ignored.
- Pointer increment: ptr+1, and if the result is ≥ MEM_DEPTH it becomes 0 (wrap).
- Out-of-range pointer (≥ MEM_DEPTH, possible only when MEM_DEPTH < 2**ADDR_SIZE):
  - A write is dropped.
  - A read loads all zeros.
  - err is set in either case.
  - The pointer still increments per the wrap rule.
- MISO is 0 in every state except RD_DATA, where it equals the shift-register MSB.
- SS_n high in any non-IDLE state → IDLE on the next edge:
  - Any partial word or partial address is discarded; no write, no pointer update.
  - Pointer increments that already happened are kept.
- Reset values:
  - state = IDLE
  - wr_ptr = rd_ptr = 0
  - shift registers = 0
  - MISO = 0, busy = 0, err = 0
- Memory contents are not reset and keep their values across rst_n.
- Reset asserted mid-transaction aborts immediately. After release, the block waits in IDLE for the next SS_n-low edge.

## Timing
- Edge numbering: edge 0 is the first edge sampling SS_n low. Opcode bits are sampled on edges 1–2. Payload bit i (0 = MSB) is sampled on edge 3+i.
- Write latency: word k's last bit is sampled on edge 2+DATA_WIDTH·(k+1). Memory and wr_ptr are updated by that edge and are visible in the following cycle.
- Read latency:
  - The load happens on edge 3.
  - MISO shows bit DATA_WIDTH−1 of word 0 after edge 3.
  - Bit j of word k is valid after edge 3+DATA_WIDTH·k+(DATA_WIDTH−1−j).
- busy rises after edge 0 and falls after the edge that samples SS_n high.
- A read and a write never occur in the same cycle, since a single engine serves both paths.

## Test plan
- Reset check, defaults: hold rst_n low, then release → MISO = 0, busy = 0, err = 0, both pointers = 0.
- Single write then read, defaults:
  - Frame 00 + 0x10, then frame 01 + 0xA5.
  - Then frame 10 + 0x10, then frame 11 → MISO emits 10100101 starting after edge 3.
- Burst with wrap, defaults:
  - Write address 0xFE, then burst-write 0x11, 0x22, 0x33 → mem[0xFE] = 0x11, mem[0xFF] = 0x22, mem[0x00] = 0x33.
  - Burst-read from 0xFE → gapless 24-bit stream 0x112233.
- Abort: raise SS_n after 5 data bits of a write → memory is unchanged, wr_ptr is unchanged, and busy falls after the next edge.
- Out-of-range, MEM_DEPTH = 200:
  - Write address 0xC8 (200), then write 0x5A → no memory change, err = 1.
  - Read from 0xC8 → MISO streams zeros.
- Reset mid-burst-read: assert rst_n low during bit 3 of word 1 → MISO = 0 and busy = 0 immediately. Previously written memory words read back intact after reset.
